seg7_scan_ctrl: RTL

- Time-multiplexed scan controller: shares one 7-segment decode path and one segment bus among NUM_DIGITS common-cathode digits.
- Host loads a full display word through a valid/ready handshake into a shadow register. The shadow commits to the displayed value only at a frame boundary, so no frame ever shows a torn value.
- A blanking interval between digits prevents ghosting.
- Sits between the hex counter logic and uo_out in the top-level.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scan_ctrl_if.sv | 12 +
 rtl/seg7_hex_decode.sv | 9 +
 rtl/seg7_scan_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: decode table, scan state
// type and width helpers.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Index is the hex value, entry is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned blank_cycles,
                                              input int unsigned dwell_cycles);
        return idx_width((blank_cycles > dwell_cycles) ? blank_cycles : dwell_cycles);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host write channel for the scan controller: one full display word per transfer.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [4*NUM_DIGITS-1:0]   wr_data;
    logic [NUM_DIGITS-1:0]     wr_dp;

    modport master (output wr_valid, output wr_data, output wr_dp, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_dp, output wr_ready);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG7_HEX[nibble];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a frame-synchronous shadow
// register so a displayed frame never mixes two host words.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_ctrl_if.slave       wr,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_start
);
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = cnt_width(BLANK_CYCLES, DWELL_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_t             state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    started_reg;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] shadow_data_reg, active_data_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg, active_dp_reg;
    logic                    pending_reg;

    logic [6:0]              segments_reg, segments_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   digit_sel_reg, digit_sel_next;
    logic                    frame_start_reg, frame_start_next;

    logic [NUM_DIGITS-1:0]   onehot_next;
    logic [3:0]              nibble_next;
    logic [6:0]              seg_decoded;
    logic                    lit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= BLANK;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            started_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            started_reg <= 1'b1;
        end
    end

    // The first edge out of reset is treated as a frame boundary so the very
    // first BLANK of digit 0 is flagged by frame_start like every other one.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg + 1'b1;
        boundary   = 1'b0;
        if (!started_reg) begin
            state_next = BLANK;
            idx_next   = '0;
            cnt_next   = '0;
            boundary   = 1'b1;
        end else begin
            case (state_reg)
                BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = SHOW;
                        cnt_next   = '0;
                    end
                end
                SHOW: begin
                    if (cnt_reg == DWELL_LAST) begin
                        state_next = BLANK;
                        cnt_next   = '0;
                        if (idx_reg == LAST_IDX) begin
                            idx_next = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end
                end
                default: state_next = BLANK;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
        assign onehot_next[gi] = (idx_next == IDX_W'(gi));
    end

    // active never changes on an edge that enters SHOW, so it can feed the decoder directly.
    assign nibble_next = active_data_reg[{idx_next, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_next),
        .seg    (seg_decoded)
    );

    always_comb begin
        lit              = (state_next == SHOW) && digit_en[idx_next];
        digit_sel_next   = lit ? onehot_next : '0;
        segments_next    = lit ? seg_decoded : '0;
        dp_next          = lit && active_dp_reg[idx_next];
        frame_start_next = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segments_reg    <= '0;
            dp_reg          <= 1'b0;
            digit_sel_reg   <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            segments_reg    <= segments_next;
            dp_reg          <= dp_next;
            digit_sel_reg   <= digit_sel_next;
            frame_start_reg <= frame_start_next;
        end
    end

    // A word accepted on the boundary edge itself waits for the next boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            active_data_reg <= '0;
            active_dp_reg   <= '0;
            pending_reg     <= 1'b0;
        end else if (boundary && pending_reg) begin
            active_data_reg <= shadow_data_reg;
            active_dp_reg   <= shadow_dp_reg;
            pending_reg     <= 1'b0;
        end else if (wr.wr_valid && !pending_reg) begin
            shadow_data_reg <= wr.wr_data;
            shadow_dp_reg   <= wr.wr_dp;
            pending_reg     <= 1'b1;
        end
    end

    assign wr.wr_ready  = !pending_reg;
    assign segments     = segments_reg;
    assign dp           = dp_reg;
    assign digit_sel    = digit_sel_reg;
    assign frame_start  = frame_start_reg;

endmodule
